// File: rtl/moesi_line_array_ctrl_if.sv
// CPU, snoop-bus and debug signals of the MOESI line-array controller.
// The controller takes the slave modport; the CPU/bus side takes the master modport.
`timescale 1ns/1ps
interface moesi_line_array_ctrl_if #(
  parameter int INDEX_W = 4
) ();
  logic               cpu_valid;
  logic               cpu_write;
  logic [INDEX_W-1:0] cpu_index;
  logic               cpu_ready;
  logic               cpu_done;
  logic [2:0]         cpu_state;

  logic               bus_req;
  logic               bus_gnt;
  logic [1:0]         bus_cmd;
  logic [INDEX_W-1:0] bus_index;
  logic               bus_done;
  logic               bus_shared_in;

  logic               snoop_valid;
  logic [1:0]         snoop_cmd;
  logic [INDEX_W-1:0] snoop_index;
  logic               snoop_shared;
  logic               snoop_intervene;
  logic               snoop_writeback;

  logic [INDEX_W-1:0] dbg_index;
  logic [2:0]         dbg_state;

  modport slave (
    input  cpu_valid, cpu_write, cpu_index,
    output cpu_ready, cpu_done, cpu_state,
    output bus_req, bus_cmd, bus_index,
    input  bus_gnt, bus_done, bus_shared_in,
    input  snoop_valid, snoop_cmd, snoop_index,
    output snoop_shared, snoop_intervene, snoop_writeback,
    input  dbg_index,
    output dbg_state
  );

  modport master (
    output cpu_valid, cpu_write, cpu_index,
    input  cpu_ready, cpu_done, cpu_state,
    input  bus_req, bus_cmd, bus_index,
    output bus_gnt, bus_done, bus_shared_in,
    output snoop_valid, snoop_cmd, snoop_index,
    input  snoop_shared, snoop_intervene, snoop_writeback,
    output dbg_index,
    input  dbg_state
  );
endinterface

// File: rtl/moesi_line_array_ctrl.sv
// Whole-cache MOESI controller: one state array, CPU requests serialised into
// bus transactions, snoops answered for every line with registered responses.
`timescale 1ns/1ps
module moesi_line_array_ctrl #(
  parameter int INDEX_W   = 4,
  parameter bit MODE_MESI = 1'b0
) (
  input logic                    clk,
  input logic                    rst_n,
  moesi_line_array_ctrl_if.slave ctrl_if
);

  localparam int NUM_LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    ST_I = 3'd0,
    ST_M = 3'd1,
    ST_S = 3'd2,
    ST_O = 3'd3,
    ST_E = 3'd4
  } line_state_t;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_RWITM = 2'd2,
    CMD_INV   = 2'd3
  } bus_cmd_t;

  typedef enum logic [1:0] {
    FSM_IDLE,
    FSM_REQ,
    FSM_XFER,
    FSM_DONE
  } fsm_t;

  line_state_t        lines [NUM_LINES];
  fsm_t               fsm;
  logic [INDEX_W-1:0] req_index;
  bus_cmd_t           req_cmd;
  logic               bus_req_q;
  logic               cpu_done_q;
  line_state_t        cpu_state_q;
  logic               snp_sh_q, snp_iv_q, snp_wb_q;

  line_state_t snp_cur, snp_next, cpu_cur, xfer_state;
  bus_cmd_t    snp_cmd;
  logic        snp_sh, snp_iv, snp_wb;
  logic        cpu_ready, accept;

  // A snoop to the requested line wins; the CPU retries next cycle.
  assign cpu_ready = (fsm == FSM_IDLE) &&
                     !(ctrl_if.snoop_valid && (ctrl_if.snoop_index == ctrl_if.cpu_index));
  assign accept    = ctrl_if.cpu_valid && cpu_ready;
  assign cpu_cur   = lines[ctrl_if.cpu_index];
  assign xfer_state = (req_cmd == CMD_READ) ? (ctrl_if.bus_shared_in ? ST_S : ST_E) : ST_M;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    snp_cmd  = bus_cmd_t'(ctrl_if.snoop_cmd);
    snp_cur  = lines[ctrl_if.snoop_index];
    snp_next = snp_cur;
    snp_sh   = 1'b0;
    snp_iv   = 1'b0;
    snp_wb   = 1'b0;
    if (ctrl_if.snoop_valid) begin
      case (snp_cur)
        ST_M, ST_O: begin
          case (snp_cmd)
            CMD_READ: begin
              // Dirty owner supplies data; MESI systems flush instead of keeping OWNED.
              snp_next = (snp_cur == ST_M && MODE_MESI) ? ST_S : ST_O;
              snp_sh   = 1'b1;
              snp_iv   = 1'b1;
              snp_wb   = (snp_cur == ST_M) && MODE_MESI;
            end
            CMD_RWITM: begin
              snp_next = ST_I;
              snp_iv   = 1'b1;
            end
            CMD_INV:  snp_next = ST_I;
            default:  ;
          endcase
        end
        ST_E, ST_S: begin
          case (snp_cmd)
            CMD_READ: begin
              snp_next = ST_S;
              snp_sh   = 1'b1;
            end
            CMD_RWITM, CMD_INV: snp_next = ST_I;
            default:            ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // NOTE: the state array is a bank of flops, so it is cleared by the async reset
  // like any other state; a RAM-style array without reset would power up as garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) lines[i] <= ST_I;
      fsm         <= FSM_IDLE;
      req_index   <= '0;
      req_cmd     <= CMD_NONE;
      bus_req_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      cpu_state_q <= ST_I;
      snp_sh_q    <= 1'b0;
      snp_iv_q    <= 1'b0;
      snp_wb_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; a later write to the same line in this
      // block (own transaction completing) deliberately overrides the snoop write.
      snp_sh_q   <= snp_sh;
      snp_iv_q   <= snp_iv;
      snp_wb_q   <= snp_wb;
      cpu_done_q <= 1'b0;
      if (ctrl_if.snoop_valid) lines[ctrl_if.snoop_index] <= snp_next;

      unique case (fsm)
        FSM_IDLE: begin
          if (accept) begin
            if (cpu_cur == ST_I) begin
              req_index <= ctrl_if.cpu_index;
              req_cmd   <= ctrl_if.cpu_write ? CMD_RWITM : CMD_READ;
              bus_req_q <= 1'b1;
              fsm       <= FSM_REQ;
            end else if (ctrl_if.cpu_write && (cpu_cur == ST_S || cpu_cur == ST_O)) begin
              req_index <= ctrl_if.cpu_index;
              req_cmd   <= CMD_INV;
              bus_req_q <= 1'b1;
              fsm       <= FSM_REQ;
            end else begin
              if (ctrl_if.cpu_write) lines[ctrl_if.cpu_index] <= ST_M;
              cpu_done_q  <= 1'b1;
              cpu_state_q <= ctrl_if.cpu_write ? ST_M : cpu_cur;
              fsm         <= FSM_DONE;
            end
          end
        end
        FSM_REQ: begin
          // Our copy was stolen while waiting: an upgrade must now fetch the data.
          if (req_cmd == CMD_INV && lines[req_index] == ST_I) req_cmd <= CMD_RWITM;
          if (ctrl_if.bus_gnt) begin
            bus_req_q <= 1'b0;
            fsm       <= FSM_XFER;
          end
        end
        FSM_XFER: begin
          if (ctrl_if.bus_done) begin
            lines[req_index] <= xfer_state;
            cpu_done_q       <= 1'b1;
            cpu_state_q      <= xfer_state;
            req_cmd          <= CMD_NONE;
            req_index        <= '0;
            fsm              <= FSM_DONE;
          end
        end
        FSM_DONE: fsm <= FSM_IDLE;
      endcase
    end
  end

  assign ctrl_if.cpu_ready       = cpu_ready;
  assign ctrl_if.cpu_done        = cpu_done_q;
  assign ctrl_if.cpu_state       = cpu_state_q;
  assign ctrl_if.bus_req         = bus_req_q;
  assign ctrl_if.bus_cmd         = req_cmd;
  assign ctrl_if.bus_index       = req_index;
  assign ctrl_if.snoop_shared    = snp_sh_q;
  assign ctrl_if.snoop_intervene = snp_iv_q;
  assign ctrl_if.snoop_writeback = snp_wb_q;
  assign ctrl_if.dbg_state       = lines[ctrl_if.dbg_index];

endmodule

// File: tb/tb_moesi_line_array_ctrl.sv
// Drives a MOESI and a MESI instance with identical stimulus and compares both
// against a per-mode line-state model kept as plain integer arrays.
`timescale 1ns/1ps
module tb_moesi_line_array_ctrl;

  localparam int I = 0, M = 1, S = 2, O = 3, E = 4;
  localparam int C_NONE = 0, C_READ = 1, C_RWITM = 2, C_INV = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #50 clk = ~clk;

  moesi_line_array_ctrl_if #(.INDEX_W(4)) if0 ();
  moesi_line_array_ctrl_if #(.INDEX_W(4)) if1 ();

  assign if1.cpu_valid     = if0.cpu_valid;
  assign if1.cpu_write     = if0.cpu_write;
  assign if1.cpu_index     = if0.cpu_index;
  assign if1.bus_gnt       = if0.bus_gnt;
  assign if1.bus_done      = if0.bus_done;
  assign if1.bus_shared_in = if0.bus_shared_in;
  assign if1.snoop_valid   = if0.snoop_valid;
  assign if1.snoop_cmd     = if0.snoop_cmd;
  assign if1.snoop_index   = if0.snoop_index;
  assign if1.dbg_index     = if0.dbg_index;

  moesi_line_array_ctrl #(.INDEX_W(4), .MODE_MESI(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .ctrl_if(if0));
  moesi_line_array_ctrl #(.INDEX_W(4), .MODE_MESI(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .ctrl_if(if1));

  int total = 0;
  int bad   = 0;
  int m [2][16];  // expected line states, [0]=MOESI instance, [1]=MESI instance

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check2(input string tag, input logic [31:0] g0, input logic [31:0] g1,
                        input logic [31:0] e0, input logic [31:0] e1);
    check({tag, ".moesi"}, g0, e0);
    check({tag, ".mesi"}, g1, e1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // What a snooping cache does with its copy, stated per transaction type.
  function automatic void snoop_model(input int md, input int st, input int cmd,
                                      output int nst, output bit sh, output bit iv, output bit wb);
    bit dirty;
    dirty = (st == M) || (st == O);
    nst = st; sh = 0; iv = 0; wb = 0;
    if (st == I || cmd == C_NONE) return;
    if (cmd == C_READ) begin
      sh = 1;
      iv = dirty;
      if (st == E) nst = S;
      if (st == M) begin
        nst = (md == 1) ? S : O;
        wb  = (md == 1);
      end
    end else begin
      nst = I;
      iv  = (cmd == C_RWITM) && dirty;
    end
  endfunction

  function automatic int plan_cmd(input int st, input bit wr);
    if (st == I) return wr ? C_RWITM : C_READ;
    if (wr && (st == S || st == O)) return C_INV;
    return C_NONE;
  endfunction

  task automatic idle_inputs();
    if0.cpu_valid = 0; if0.cpu_write = 0; if0.cpu_index = 0;
    if0.bus_gnt = 0; if0.bus_done = 0; if0.bus_shared_in = 0;
    if0.snoop_valid = 0; if0.snoop_cmd = 0; if0.snoop_index = 0; if0.dbg_index = 0;
  endtask

  task automatic check_array(input string tag);
    for (int i = 0; i < 16; i++) begin
      if0.dbg_index = 4'(i);
      #1;
      check2($sformatf("%s.dbg[%0d]", tag, i), if0.dbg_state, if1.dbg_state, m[0][i], m[1][i]);
    end
  endtask

  task automatic check_resp(input string tag, input bit sh0, input bit iv0, input bit wb0,
                            input bit sh1, input bit iv1, input bit wb1);
    check2({tag, ".shared"}, if0.snoop_shared, if1.snoop_shared, sh0, sh1);
    check2({tag, ".intervene"}, if0.snoop_intervene, if1.snoop_intervene, iv0, iv1);
    check2({tag, ".writeback"}, if0.snoop_writeback, if1.snoop_writeback, wb0, wb1);
  endtask

  task automatic snoop_op(input int idx, input int cmd);
    int nst [2];
    bit sh [2], iv [2], wb [2];
    for (int md = 0; md < 2; md++) snoop_model(md, m[md][idx], cmd, nst[md], sh[md], iv[md], wb[md]);
    if0.snoop_valid = 1; if0.snoop_index = 4'(idx); if0.snoop_cmd = 2'(cmd);
    tick();
    if0.snoop_valid = 0;
    check_resp($sformatf("snoop%0d@%0d", cmd, idx), sh[0], iv[0], wb[0], sh[1], iv[1], wb[1]);
    for (int md = 0; md < 2; md++) m[md][idx] = nst[md];
    if0.dbg_index = 4'(idx);
    #1;
    check2($sformatf("snoop.dbg[%0d]", idx), if0.dbg_state, if1.dbg_state, m[0][idx], m[1][idx]);
    tick();
    check_resp("snoop.pulse_end", 0, 0, 0, 0, 0, 0);
  endtask

  // One CPU request, optionally with a concurrent snoop to a different line.
  task automatic cpu_op(input int idx, input bit wr, input int gnt_dly, input int done_dly,
                        input bit shared, input bit sn_en, input int sn_idx, input int sn_cmd);
    int cmd [2], fin [2], nst [2];
    bit sh [2], iv [2], wb [2];
    if0.cpu_valid = 1; if0.cpu_write = wr; if0.cpu_index = 4'(idx);
    if0.snoop_valid = sn_en; if0.snoop_index = 4'(sn_idx); if0.snoop_cmd = 2'(sn_cmd);
    #1;
    check2($sformatf("ready@%0d", idx), if0.cpu_ready, if1.cpu_ready, 1, 1);
    for (int md = 0; md < 2; md++) begin
      cmd[md] = plan_cmd(m[md][idx], wr);
      snoop_model(md, m[md][sn_idx], sn_en ? sn_cmd : C_NONE, nst[md], sh[md], iv[md], wb[md]);
    end
    tick();
    if0.cpu_valid = 0; if0.snoop_valid = 0;
    check_resp("cc_snoop", sh[0], iv[0], wb[0], sh[1], iv[1], wb[1]);
    for (int md = 0; md < 2; md++) m[md][sn_idx] = nst[md];
    if (cmd[0] == C_NONE) begin
      for (int md = 0; md < 2; md++) fin[md] = wr ? M : m[md][idx];
      check2("hit.done", if0.cpu_done, if1.cpu_done, 1, 1);
      check2("hit.state", if0.cpu_state, if1.cpu_state, fin[0], fin[1]);
      check2("hit.bus_req", if0.bus_req, if1.bus_req, 0, 0);
    end else begin
      check2("miss.bus_req", if0.bus_req, if1.bus_req, 1, 1);
      check2("miss.bus_cmd", if0.bus_cmd, if1.bus_cmd, cmd[0], cmd[1]);
      check2("miss.bus_index", if0.bus_index, if1.bus_index, idx, idx);
      check2("miss.early_done", if0.cpu_done, if1.cpu_done, 0, 0);
      repeat (gnt_dly) begin
        tick();
        check2("req.held", if0.bus_req, if1.bus_req, 1, 1);
      end
      if0.bus_gnt = 1;
      tick();
      if0.bus_gnt = 0;
      check2("gnt.req_drop", if0.bus_req, if1.bus_req, 0, 0);
      repeat (done_dly) begin
        tick();
        check2("xfer.wait", if0.cpu_done, if1.cpu_done, 0, 0);
      end
      if0.bus_done = 1; if0.bus_shared_in = shared;
      tick();
      if0.bus_done = 0; if0.bus_shared_in = 0;
      for (int md = 0; md < 2; md++) fin[md] = (cmd[md] == C_READ) ? (shared ? S : E) : M;
      check2("miss.done", if0.cpu_done, if1.cpu_done, 1, 1);
      check2("miss.state", if0.cpu_state, if1.cpu_state, fin[0], fin[1]);
      check2("miss.cmd_clear", if0.bus_cmd, if1.bus_cmd, 0, 0);
    end
    for (int md = 0; md < 2; md++) m[md][idx] = fin[md];
    tick();
    check2("done.pulse_end", if0.cpu_done, if1.cpu_done, 0, 0);
    check2("back_idle", if0.cpu_ready, if1.cpu_ready, 1, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nst0, nst1;
    bit sh, iv, wb;
    idle_inputs();
    for (int md = 0; md < 2; md++) for (int i = 0; i < 16; i++) m[md][i] = I;

    // Reset state
    repeat (3) @(posedge clk);
    #10;
    check2("rst.bus_req", if0.bus_req, if1.bus_req, 0, 0);
    check2("rst.cpu_done", if0.cpu_done, if1.cpu_done, 0, 0);
    check2("rst.bus_cmd", if0.bus_cmd, if1.bus_cmd, 0, 0);
    rst_n = 1;
    tick();
    check2("rst.ready", if0.cpu_ready, if1.cpu_ready, 1, 1);
    check_resp("rst", 0, 0, 0, 0, 0, 0);
    check_array("rst");

    // Write miss idx 3, read miss idx 5 exclusive then silent upgrade
    cpu_op(3, 1, 1, 1, 0, 0, 0, 0);
    cpu_op(5, 0, 0, 2, 0, 0, 0, 0);
    cpu_op(5, 1, 0, 0, 0, 0, 0, 0);

    // Modified line snooped by a reader: O (MOESI) vs S + writeback (MESI)
    cpu_op(2, 1, 0, 0, 0, 0, 0, 0);
    snoop_op(2, C_READ);

    // Upgrade of S loses its copy while waiting for the bus
    cpu_op(7, 0, 0, 0, 1, 0, 0, 0);
    if0.cpu_valid = 1; if0.cpu_write = 1; if0.cpu_index = 7;
    tick();
    if0.cpu_valid = 0;
    check2("up.cmd_inv", if0.bus_cmd, if1.bus_cmd, C_INV, C_INV);
    snoop_model(0, m[0][7], C_RWITM, nst0, sh, iv, wb);
    snoop_model(1, m[1][7], C_RWITM, nst1, sh, iv, wb);
    if0.snoop_valid = 1; if0.snoop_cmd = C_RWITM; if0.snoop_index = 7;
    tick();
    if0.snoop_valid = 0;
    m[0][7] = nst0; m[1][7] = nst1;
    check_resp("up.snoop", 0, 0, 0, 0, 0, 0);
    tick();
    check2("up.cmd_rwitm", if0.bus_cmd, if1.bus_cmd, C_RWITM, C_RWITM);
    check2("up.req_held", if0.bus_req, if1.bus_req, 1, 1);
    if0.bus_gnt = 1;
    tick();
    if0.bus_gnt = 0;
    if0.bus_done = 1;
    tick();
    if0.bus_done = 0;
    check2("up.done", if0.cpu_done, if1.cpu_done, 1, 1);
    check2("up.state", if0.cpu_state, if1.cpu_state, M, M);
    m[0][7] = M; m[1][7] = M;
    tick();

    // Snoop and CPU to the same line in the same cycle
    if0.cpu_valid = 1; if0.cpu_write = 0; if0.cpu_index = 4;
    if0.snoop_valid = 1; if0.snoop_cmd = C_READ; if0.snoop_index = 4;
    #1;
    check2("clash.ready", if0.cpu_ready, if1.cpu_ready, 0, 0);
    tick();
    if0.snoop_valid = 0;
    check2("clash.no_req", if0.bus_req, if1.bus_req, 0, 0);
    check2("clash.no_done", if0.cpu_done, if1.cpu_done, 0, 0);
    cpu_op(4, 0, 1, 0, 0, 0, 0, 0);
    check_array("directed");

    // Randomized mix of requests and snoops
    for (int n = 0; n < 200; n++) begin
      int idx, wr, sn_en, sn_idx, sn_cmd;
      idx = $urandom_range(0, 7);
      if ($urandom_range(0, 9) < 6) begin
        wr     = $urandom_range(0, 1);
        sn_en  = $urandom_range(0, 1);
        sn_idx = (idx + $urandom_range(1, 7)) % 8;
        sn_cmd = $urandom_range(0, 3);
        cpu_op(idx, wr[0], $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
               sn_en[0], sn_idx, sn_cmd);
      end else begin
        snoop_op(idx, $urandom_range(0, 3));
      end
      if (n % 40 == 39) check_array("rand");
    end

    // Reset in the middle of a bus transfer
    if0.cpu_valid = 1; if0.cpu_write = 1; if0.cpu_index = 9;
    tick();
    if0.cpu_valid = 0;
    check2("rx.bus_req", if0.bus_req, if1.bus_req, 1, 1);
    if0.bus_gnt = 1;
    tick();
    if0.bus_gnt = 0;
    #20;
    rst_n = 0;
    #1;
    check2("rx.req_drop", if0.bus_req, if1.bus_req, 0, 0);
    check2("rx.cmd_drop", if0.bus_cmd, if1.bus_cmd, 0, 0);
    if0.bus_done = 1;
    tick();
    if0.bus_done = 0;
    check2("rx.no_done", if0.cpu_done, if1.cpu_done, 0, 0);
    rst_n = 1;
    for (int md = 0; md < 2; md++) for (int i = 0; i < 16; i++) m[md][i] = I;
    tick();
    check2("rx.no_done2", if0.cpu_done, if1.cpu_done, 0, 0);
    check2("rx.ready", if0.cpu_ready, if1.cpu_ready, 1, 1);
    check_array("rx");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
